// File: rtl/key_schedule_sequencer.sv
// rtl/key_schedule_sequencer.sv - round-key sequencer wrapped around the key_schedule round function

// key_schedule - combinational round function: round 1 applies fi only, later rounds add a round constant
module key_schedule (
  input  logic [127:0] data_in,
  input  logic [3:0]   round_counter,
  output logic [127:0] data_out
);

  logic [127:0] rot8;
  logic [127:0] rot1;
  logic [127:0] rot2;
  logic [127:0] fi;
  logic [127:0] rconst;

  assign rot8   = {data_in[119:0], data_in[127:120]};
  assign rot1   = {data_in[126:0], data_in[127]};
  assign rot2   = {data_in[125:0], data_in[127:126]};
  // byte-wise diffusion plus a chi-style nonlinear term
  assign fi     = rot8 ^ (rot1 & ~rot2);
  assign rconst = {16{4'h0, round_counter}};

  // round 1 takes the raw fi path, all other rounds mix in the round constant
  always_comb begin
    data_out = fi;
    if (round_counter != 4'd1) begin
      data_out = fi ^ rconst;
    end
  end

endmodule

// key_schedule_sequencer - iterates key_schedule over rounds 1..NUM_KEYS and streams each state out
module key_schedule_sequencer #(
  parameter int NUM_KEYS = 13
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic         flush,
  output logic [127:0] data_out,
  output logic [3:0]   round_out,
  output logic         data_valid,
  input  logic         data_ready,
  output logic         last,
  output logic         busy
);

  localparam logic [3:0] LAST_RC = 4'(NUM_KEYS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t       state;
  logic [127:0] key_st;
  logic [3:0]   rc;
  logic [127:0] ks_out;

  key_schedule u_key_schedule (
    .data_in       (key_st),
    .round_counter (rc),
    .data_out      (ks_out)
  );

  assign key_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign last      = data_valid && (round_out == LAST_RC);

  // sequencer FSM: load key, compute one round per CALC, hold each result until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      key_st     <= '0;
      rc         <= '0;
      data_out   <= '0;
      round_out  <= '0;
      data_valid <= 1'b0;
    end else if (flush) begin
      // abort wins over everything; key_st is left as-is
      state      <= IDLE;
      rc         <= '0;
      data_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (key_valid) begin
            key_st <= key_in;
            rc     <= 4'd1;
            state  <= CALC;
          end
        end
        CALC: begin
          key_st     <= ks_out;
          data_out   <= ks_out;
          round_out  <= rc;
          data_valid <= 1'b1;
          state      <= HOLD;
        end
        HOLD: begin
          if (data_ready) begin
            data_valid <= 1'b0;
            if (rc == LAST_RC) begin
              state <= IDLE;
            end else begin
              rc    <= rc + 4'd1;
              state <= CALC;
            end
          end
        end
        default: begin
          state      <= IDLE;
          data_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
